// File: rtl/lc3b_control_pkg.sv
// ============================================================================
// Package : lc3b_types
// Brief   : Shared LC-3b opcodes, datapath mux select codes and ALU operations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000, OP_ADD  = 4'b0001, OP_LDB  = 4'b0010, OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100, OP_AND  = 4'b0101, OP_LDR  = 4'b0110, OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000, OP_NOT  = 4'b1001, OP_LDI  = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100, OP_SHF  = 4'b1101, OP_LEA  = 4'b1110, OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_NOT  = 2'd2,
    ALU_PASS = 2'd3
  } lc3b_aluop;

  localparam logic [1:0] PCMUX_PC2       = 2'd0;
  localparam logic [1:0] PCMUX_BR_ADD    = 2'd1;
  localparam logic [1:0] PCMUX_SR1       = 2'd2;
  localparam logic [1:0] ALUMUX_SR2      = 2'd0;
  localparam logic [1:0] ALUMUX_ADJ6     = 2'd1;
  localparam logic [1:0] ALUMUX_IMM5     = 2'd2;
  localparam logic       MARMUX_ALU      = 1'b0;
  localparam logic       MARMUX_PC       = 1'b1;
  localparam logic       MDRMUX_ALU      = 1'b0;
  localparam logic       MDRMUX_MEM      = 1'b1;
  localparam logic       REGFILEMUX_ALU  = 1'b0;
  localparam logic       REGFILEMUX_MDR  = 1'b1;
  localparam logic       STOREMUX_SR1    = 1'b0;
  localparam logic       STOREMUX_DEST   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lc3b_control.sv
// ============================================================================
// Module  : lc3b_control
// Brief   : Multicycle LC-3b control FSM with retired-instruction counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic                 branch_enable,
  input  logic                 imm5_enable,
  input  logic                 mem_resp,
  output logic [1:0]           pcmux_sel,
  output logic                 load_pc,
  output logic                 load_ir,
  output logic                 load_regfile,
  output logic                 load_mar,
  output logic                 load_mdr,
  output logic                 load_cc,
  output logic                 storemux_sel,
  output logic [1:0]           alumux_sel,
  output logic                 regfilemux_sel,
  output logic                 marmux_sel,
  output logic                 mdrmux_sel,
  output logic [1:0]           aluop,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH1    = 4'd0,
    FETCH2    = 4'd1,
    FETCH3    = 4'd2,
    DECODE    = 4'd3,
    ALU_OP    = 4'd4,
    CALC_ADDR = 4'd5,
    LDR1      = 4'd6,
    LDR2      = 4'd7,
    STR1      = 4'd8,
    STR2      = 4'd9,
    BR_CHK    = 4'd10,
    BR_TAKEN  = 4'd11,
    JMP       = 4'd12
  } lc3b_control_state;

  lc3b_control_state state, next_state;

  // Every return to FETCH1 retires exactly one instruction, including no-ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH1;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (next_state == FETCH1)
        instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    next_state     = state;
    pcmux_sel      = PCMUX_PC2;
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    storemux_sel   = STOREMUX_SR1;
    alumux_sel     = ALUMUX_SR2;
    regfilemux_sel = REGFILEMUX_ALU;
    marmux_sel     = MARMUX_ALU;
    mdrmux_sel     = MDRMUX_ALU;
    aluop          = ALU_ADD;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    case (state)
      FETCH1: begin
        marmux_sel = MARMUX_PC;
        load_mar   = 1'b1;
        load_pc    = 1'b1;
        next_state = FETCH2;
      end
      FETCH2: begin
        mem_read   = 1'b1;
        mdrmux_sel = MDRMUX_MEM;
        load_mdr   = 1'b1;
        if (mem_resp) next_state = FETCH3;
      end
      FETCH3: begin
        load_ir    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: next_state = ALU_OP;
          OP_LDR, OP_STR:         next_state = CALC_ADDR;
          OP_BR:                  next_state = BR_CHK;
          OP_JMP:                 next_state = JMP;
          default:                next_state = FETCH1;
        endcase
      end
      ALU_OP: begin
        case (opcode)
          OP_AND:  aluop = ALU_AND;
          OP_NOT:  aluop = ALU_NOT;
          default: aluop = ALU_ADD;
        endcase
        if (imm5_enable && opcode != OP_NOT) alumux_sel = ALUMUX_IMM5;
        load_regfile = 1'b1;
        load_cc      = 1'b1;
        next_state   = FETCH1;
      end
      CALC_ADDR: begin
        alumux_sel = ALUMUX_ADJ6;
        load_mar   = 1'b1;
        next_state = (opcode == OP_LDR) ? LDR1 : STR1;
      end
      LDR1: begin
        mem_read   = 1'b1;
        mdrmux_sel = MDRMUX_MEM;
        load_mdr   = 1'b1;
        if (mem_resp) next_state = LDR2;
      end
      LDR2: begin
        regfilemux_sel = REGFILEMUX_MDR;
        load_regfile   = 1'b1;
        load_cc        = 1'b1;
        next_state     = FETCH1;
      end
      STR1: begin
        storemux_sel = STOREMUX_DEST;
        aluop        = ALU_PASS;
        load_mdr     = 1'b1;
        next_state   = STR2;
      end
      STR2: begin
        mem_write = 1'b1;
        if (mem_resp) next_state = FETCH1;
      end
      BR_CHK:   next_state = branch_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN: begin
        pcmux_sel  = PCMUX_BR_ADD;
        load_pc    = 1'b1;
        next_state = FETCH1;
      end
      JMP: begin
        pcmux_sel  = PCMUX_SR1;
        load_pc    = 1'b1;
        next_state = FETCH1;
      end
      default: next_state = FETCH1;
    endcase

    // Reset squashes side effects combinationally so an in-flight access ends this cycle.
    if (reset) begin
      load_pc      = 1'b0;
      load_ir      = 1'b0;
      load_regfile = 1'b0;
      load_mar     = 1'b0;
      load_mdr     = 1'b0;
      load_cc      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3b_control.sv
// ============================================================================
// Module  : tb_lc3b_control
// Brief   : Scoreboard bench for lc3b_control with directed instruction sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3b_control;
  import lc3b_types::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    opcode = OP_ADD;
  logic          branch_enable = 1'b0;
  logic          imm5_enable = 1'b1;
  logic          mem_resp = 1'b0;
  logic [1:0]    pcmux_sel, alumux_sel, aluop;
  logic          load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic          storemux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  logic          mem_read, mem_write;
  logic [CW-1:0] instr_count;

  lc3b_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_enable(branch_enable),
    .imm5_enable(imm5_enable), .mem_resp(mem_resp), .pcmux_sel(pcmux_sel),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .storemux_sel(storemux_sel), .alumux_sel(alumux_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
    .mdrmux_sel(mdrmux_sel), .aluop(aluop), .mem_read(mem_read),
    .mem_write(mem_write), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pcmux;
    logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_cc, storemux;
    logic [1:0] alumux;
    logic       rfmux, marmux, mdrmux;
    logic [1:0] aluop;
    logic       rd, wr;
    logic [1:0] cnt;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Expected Moore outputs per state, taken from the state table; "RST" is FETCH1 under reset.
  function automatic vec_t exp_of(input string st);
    vec_t e = '0;
    case (st)
      "RST":       e.marmux = 1'b1;
      "FETCH1":    begin e.marmux = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; end
      "FETCH2",
      "LDR1":      begin e.rd = 1'b1; e.mdrmux = 1'b1; e.ld_mdr = 1'b1; end
      "FETCH3":    e.ld_ir = 1'b1;
      "ALU_OP": begin
        e.aluop  = (opcode == OP_AND) ? 2'd1 : (opcode == OP_NOT) ? 2'd2 : 2'd0;
        e.alumux = (imm5_enable && opcode != OP_NOT) ? 2'd2 : 2'd0;
        e.ld_rf = 1'b1; e.ld_cc = 1'b1;
      end
      "CALC_ADDR": begin e.alumux = 2'd1; e.ld_mar = 1'b1; end
      "LDR2":      begin e.rfmux = 1'b1; e.ld_rf = 1'b1; e.ld_cc = 1'b1; end
      "STR1":      begin e.storemux = 1'b1; e.aluop = 2'd3; e.ld_mdr = 1'b1; end
      "STR2":      e.wr = 1'b1;
      "BR_TAKEN":  begin e.pcmux = 2'd1; e.ld_pc = 1'b1; end
      "JMP":       begin e.pcmux = 2'd2; e.ld_pc = 1'b1; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input string st, input logic r, input logic resp, input logic [1:0] cnt);
    item_t it;
    @(posedge clk);
    #1;
    reset    = r;
    mem_resp = resp;
    it.name  = st;
    it.v     = exp_of(st);
    it.v.cnt = cnt;
    sb.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    vec_t  act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {pcmux_sel, load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel, aluop,
               mem_read, mem_write, instr_count};
        n_cmp++;
        if (act !== it.v || (mem_read && mem_write)) begin
          n_bad++;
          $display("FAIL %s cmp#%0d: got %05h expected %05h", it.name, n_cmp, act, it.v);
        end
      end
    end
  end

  initial begin : driver
    // Reset state, then reset asserted mid-FETCH2
    step("RST", 1, 0, 0);
    step("FETCH1", 0, 0, 0);
    step("FETCH2", 0, 0, 0);
    step("RST", 1, 0, 0);
    // ADD R1,R2,#-3
    step("FETCH1", 0, 0, 0);
    opcode = OP_ADD; imm5_enable = 1'b1;
    step("FETCH2", 0, 1, 0);
    step("FETCH3", 0, 0, 0);
    step("DECODE", 0, 0, 0);
    step("ALU_OP", 0, 0, 0);
    // LDR with three-cycle memory wait
    step("FETCH1", 0, 0, 1);
    opcode = OP_LDR;
    step("FETCH2", 0, 1, 1);
    step("FETCH3", 0, 0, 1);
    step("DECODE", 0, 0, 1);
    step("CALC_ADDR", 0, 0, 1);
    step("LDR1", 0, 0, 1);
    step("LDR1", 0, 0, 1);
    step("LDR1", 0, 1, 1);
    step("LDR2", 0, 0, 1);
    // STR with one wait cycle in STR2
    step("FETCH1", 0, 0, 2);
    opcode = OP_STR;
    step("FETCH2", 0, 1, 2);
    step("FETCH3", 0, 0, 2);
    step("DECODE", 0, 0, 2);
    step("CALC_ADDR", 0, 0, 2);
    step("STR1", 0, 0, 2);
    step("STR2", 0, 0, 2);
    step("STR2", 0, 1, 2);
    // BR not taken; counter wraps 3 -> 0 on return to FETCH1
    step("FETCH1", 0, 0, 3);
    opcode = OP_BR; branch_enable = 1'b0;
    step("FETCH2", 0, 1, 3);
    step("FETCH3", 0, 0, 3);
    step("DECODE", 0, 0, 3);
    step("BR_CHK", 0, 0, 3);
    // BR taken
    step("FETCH1", 0, 0, 0);
    branch_enable = 1'b1;
    step("FETCH2", 0, 1, 0);
    step("FETCH3", 0, 0, 0);
    step("DECODE", 0, 0, 0);
    step("BR_CHK", 0, 0, 0);
    step("BR_TAKEN", 0, 0, 0);
    // JMP
    step("FETCH1", 0, 0, 1);
    opcode = OP_JMP; branch_enable = 1'b0;
    step("FETCH2", 0, 1, 1);
    step("FETCH3", 0, 0, 1);
    step("DECODE", 0, 0, 1);
    step("JMP", 0, 0, 1);
    // Unsupported opcode retires as a no-op
    step("FETCH1", 0, 0, 2);
    opcode = 4'b1101;
    step("FETCH2", 0, 1, 2);
    step("FETCH3", 0, 0, 2);
    step("DECODE", 0, 0, 2);
    // AND register form
    step("FETCH1", 0, 0, 3);
    opcode = OP_AND; imm5_enable = 1'b0;
    step("FETCH2", 0, 1, 3);
    step("FETCH3", 0, 0, 3);
    step("DECODE", 0, 0, 3);
    step("ALU_OP", 0, 0, 3);
    // NOT with imm5 set and stray mem_resp outside wait states
    step("FETCH1", 0, 1, 0);
    opcode = OP_NOT; imm5_enable = 1'b1;
    step("FETCH2", 0, 0, 0);
    step("FETCH2", 0, 1, 0);
    step("FETCH3", 0, 1, 0);
    step("DECODE", 0, 1, 0);
    step("ALU_OP", 0, 1, 0);
    step("FETCH1", 0, 0, 1);
    mem_resp = 1'b0;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
